// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side inputs, forwarding sources and the registered
// EX-side outputs, grouped for the pipeline register.
interface id_ex_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic              Valid_i;
  logic              Stall_i;
  logic              Flush_i;
  logic [31:0]       Rs1Data_i;
  logic [31:0]       Rs2Data_i;
  logic [31:0]       Imm_i;
  logic [4:0]        Rs1Addr_i;
  logic [4:0]        Rs2Addr_i;
  logic [4:0]        RdAddr_i;
  logic [2:0]        Funct3_i;
  logic [6:0]        Funct7_i;
  logic [1:0]        ALUOp_i;
  logic              ALUSrc_i;
  logic              RegWrite_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic              ExMemRegWrite_i;
  logic [4:0]        ExMemRd_i;
  logic [31:0]       ExMemResult_i;
  logic              MemWbRegWrite_i;
  logic [4:0]        MemWbRd_i;
  logic [31:0]       MemWbResult_i;

  logic              Valid_o;
  logic [31:0]       OperandA_o;
  logic [31:0]       OperandB_o;
  logic [31:0]       StoreData_o;
  logic [2:0]        Funct3_o;
  logic [6:0]        Funct7_o;
  logic [1:0]        ALUOp_o;
  logic [4:0]        RdAddr_o;
  logic              RegWrite_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic              LoadUseHazard_o;
  logic [CNT_W-1:0]  BubbleCnt_o;

  modport master (
    output Valid_i, Stall_i, Flush_i, Rs1Data_i, Rs2Data_i, Imm_i,
           Rs1Addr_i, Rs2Addr_i, RdAddr_i, Funct3_i, Funct7_i, ALUOp_i,
           ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i,
           ExMemRegWrite_i, ExMemRd_i, ExMemResult_i,
           MemWbRegWrite_i, MemWbRd_i, MemWbResult_i,
    input  Valid_o, OperandA_o, OperandB_o, StoreData_o, Funct3_o, Funct7_o,
           ALUOp_o, RdAddr_o, RegWrite_o, MemRead_o, MemWrite_o,
           LoadUseHazard_o, BubbleCnt_o
  );

  modport slave (
    input  Valid_i, Stall_i, Flush_i, Rs1Data_i, Rs2Data_i, Imm_i,
           Rs1Addr_i, Rs2Addr_i, RdAddr_i, Funct3_i, Funct7_i, ALUOp_i,
           ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i,
           ExMemRegWrite_i, ExMemRd_i, ExMemResult_i,
           MemWbRegWrite_i, MemWbRd_i, MemWbResult_i,
    output Valid_o, OperandA_o, OperandB_o, StoreData_o, Funct3_o, Funct7_o,
           ALUOp_o, RdAddr_o, RegWrite_o, MemRead_o, MemWrite_o,
           LoadUseHazard_o, BubbleCnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall/load-use bubble control,
// EX/MEM and MEM/WB operand forwarding and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic          Clk_i,
  input  logic          Rst_i,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } stage_t;

  stage_t           stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             bubble;
  logic [31:0]      fwd_rs1, fwd_rs2;

  // Hazard is suppressed by stall/flush so upstream never sees a stale hold request.
  always_comb begin
    load_use = !bus.Stall_i && !bus.Flush_i &&
               stage_q.valid && stage_q.memread && (stage_q.rd != '0) &&
               bus.Valid_i &&
               ((stage_q.rd == bus.Rs1Addr_i) || (stage_q.rd == bus.Rs2Addr_i));
  end

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;
    if (bus.Flush_i) begin
      bubble = 1'b1;
    end else if (bus.Stall_i) begin
      stage_d = stage_q;
    end else if (load_use) begin
      bubble = 1'b1;
    end else begin
      stage_d.valid    = bus.Valid_i;
      stage_d.rs1_data = bus.Rs1Data_i;
      stage_d.rs2_data = bus.Rs2Data_i;
      stage_d.imm      = bus.Imm_i;
      stage_d.rs1_addr = bus.Rs1Addr_i;
      stage_d.rs2_addr = bus.Rs2Addr_i;
      stage_d.rd       = bus.RdAddr_i;
      stage_d.funct3   = bus.Funct3_i;
      stage_d.funct7   = bus.Funct7_i;
      stage_d.aluop    = bus.ALUOp_i;
      stage_d.alusrc   = bus.ALUSrc_i;
      stage_d.regwrite = bus.RegWrite_i & bus.Valid_i;
      stage_d.memread  = bus.MemRead_i  & bus.Valid_i;
      stage_d.memwrite = bus.MemWrite_i & bus.Valid_i;
    end
    if (bubble) begin
      stage_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = stage_q.rs1_data;
    if (bus.ExMemRegWrite_i && (bus.ExMemRd_i != '0) && (bus.ExMemRd_i == stage_q.rs1_addr)) begin
      fwd_rs1 = bus.ExMemResult_i;
    end else if (bus.MemWbRegWrite_i && (bus.MemWbRd_i != '0) && (bus.MemWbRd_i == stage_q.rs1_addr)) begin
      fwd_rs1 = bus.MemWbResult_i;
    end
  end

  always_comb begin
    fwd_rs2 = stage_q.rs2_data;
    if (bus.ExMemRegWrite_i && (bus.ExMemRd_i != '0) && (bus.ExMemRd_i == stage_q.rs2_addr)) begin
      fwd_rs2 = bus.ExMemResult_i;
    end else if (bus.MemWbRegWrite_i && (bus.MemWbRd_i != '0) && (bus.MemWbRd_i == stage_q.rs2_addr)) begin
      fwd_rs2 = bus.MemWbResult_i;
    end
  end

  assign bus.Valid_o         = stage_q.valid;
  assign bus.OperandA_o      = fwd_rs1;
  assign bus.OperandB_o      = stage_q.alusrc ? stage_q.imm : fwd_rs2;
  assign bus.StoreData_o     = fwd_rs2;
  assign bus.Funct3_o        = stage_q.funct3;
  assign bus.Funct7_o        = stage_q.funct7;
  assign bus.ALUOp_o         = stage_q.aluop;
  assign bus.RdAddr_o        = stage_q.rd;
  assign bus.RegWrite_o      = stage_q.regwrite;
  assign bus.MemRead_o       = stage_q.memread;
  assign bus.MemWrite_o      = stage_q.memwrite;
  assign bus.LoadUseHazard_o = load_use;
  assign bus.BubbleCnt_o     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected registered outputs
// plus direct checks of the combinational forwarding and hazard paths.
module tb_id_ex_stage;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          dchk;
    logic          v;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   sd;
    logic [4:0]    rd;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [1:0]    op;
    logic          rw;
    logic          mr;
    logic          mw;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  id_ex_stage_if #(.CNT_W(CW)) bus ();

  id_ex_stage #(.CNT_W(CW)) dut (
    .Clk_i (clk),
    .Rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r1d, input logic [31:0] r2d,
                       input logic [31:0] imm, input logic [4:0] r1a, input logic [4:0] r2a,
                       input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [1:0] op, input logic src, input logic rw,
                       input logic mr, input logic mw);
    bus.Valid_i   = v;   bus.Rs1Data_i = r1d; bus.Rs2Data_i = r2d; bus.Imm_i = imm;
    bus.Rs1Addr_i = r1a; bus.Rs2Addr_i = r2a; bus.RdAddr_i  = rd;
    bus.Funct3_i  = f3;  bus.Funct7_i  = f7;  bus.ALUOp_i   = op;  bus.ALUSrc_i = src;
    bus.RegWrite_i = rw; bus.MemRead_i = mr;  bus.MemWrite_i = mw;
  endtask

  // Expected result of a normal load with no forwarding active at sample time.
  function automatic exp_t model(input logic v, input logic [31:0] r1d, input logic [31:0] r2d,
                                 input logic [31:0] imm, input logic [4:0] rd, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [1:0] op, input logic src,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic [CW-1:0] cnt);
    exp_t e;
    e.dchk = v;  e.v = v;  e.a = r1d;  e.b = src ? imm : r2d;  e.sd = r2d;
    e.rd = rd;   e.f3 = f3; e.f7 = f7; e.op = op;
    e.rw = rw & v; e.mr = mr & v; e.mw = mw & v; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t bubble_exp(input logic [CW-1:0] cnt);
    exp_t e;
    e = '0;
    e.dchk = 1'b1;
    e.cnt  = cnt;
    return e;
  endfunction

  task automatic check_sb(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, bus.Valid_o, e.v);
      chk({tag, "_regwrite"}, bus.RegWrite_o, e.rw);
      chk({tag, "_memread"}, bus.MemRead_o, e.mr);
      chk({tag, "_memwrite"}, bus.MemWrite_o, e.mw);
      chk({tag, "_cnt"}, 32'(bus.BubbleCnt_o), 32'(e.cnt));
      if (e.dchk) begin
        chk({tag, "_opa"}, bus.OperandA_o, e.a);
        chk({tag, "_opb"}, bus.OperandB_o, e.b);
        chk({tag, "_store"}, bus.StoreData_o, e.sd);
        chk({tag, "_rd"}, 32'(bus.RdAddr_o), 32'(e.rd));
        chk({tag, "_f3"}, 32'(bus.Funct3_o), 32'(e.f3));
        chk({tag, "_f7"}, 32'(bus.Funct7_o), 32'(e.f7));
        chk({tag, "_aluop"}, 32'(bus.ALUOp_o), 32'(e.op));
      end
    end
  endtask

  initial begin
    logic [CW-1:0] ecnt;
    n_assert = 0;
    n_fail   = 0;
    ecnt     = '0;
    rst      = 1'b1;
    bus.Stall_i = 1'b0; bus.Flush_i = 1'b0;
    bus.ExMemRegWrite_i = 1'b0; bus.ExMemRd_i = '0; bus.ExMemResult_i = '0;
    bus.MemWbRegWrite_i = 1'b0; bus.MemWbRd_i = '0; bus.MemWbResult_i = '0;
    drive(1'b1, 32'd5, 32'd6, 32'd7, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    chk("reset_valid", bus.Valid_o, 1'b0);
    chk("reset_opa", bus.OperandA_o, 32'd0);
    chk("reset_cnt", 32'(bus.BubbleCnt_o), 32'd0);
    chk("reset_haz", bus.LoadUseHazard_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // pass-through, immediate select, store
    drive(1'b1, 32'd20, 32'd30, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(model(1'b1, 32'd20, 32'd30, 32'd0, 5'd3, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("pass");
    drive(1'b1, 32'hAAAA, 32'd9, 32'h55, 5'd4, 5'd6, 5'd10, 3'd5, 7'h20, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back(model(1'b1, 32'hAAAA, 32'd9, 32'h55, 5'd10, 3'd5, 7'h20, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("imm");
    drive(1'b1, 32'h100, 32'hBEEF, 32'd8, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    sb.push_back(model(1'b1, 32'h100, 32'hBEEF, 32'd8, 5'd0, 3'd2, 7'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, ecnt));
    step(); check_sb("store");
    drive(1'b0, 32'd1, 32'd2, 32'd3, 5'd1, 5'd2, 5'd5, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    sb.push_back(model(1'b0, 32'd1, 32'd2, 32'd3, 5'd5, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, ecnt));
    step(); check_sb("invalid");

    // forwarding priority on rs1 = x5, rs2 = x6
    drive(1'b1, 32'd7, 32'd8, 32'd0, 5'd5, 5'd6, 5'd3, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(model(1'b1, 32'd7, 32'd8, 32'd0, 5'd3, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("fwd_base");
    bus.ExMemRegWrite_i = 1'b1; bus.ExMemRd_i = 5'd5; bus.ExMemResult_i = 32'd100;
    bus.MemWbRegWrite_i = 1'b1; bus.MemWbRd_i = 5'd5; bus.MemWbResult_i = 32'd200;
    #1 chk("fwd_exmem_wins", bus.OperandA_o, 32'd100);
    bus.ExMemRegWrite_i = 1'b0;
    #1 chk("fwd_memwb", bus.OperandA_o, 32'd200);
    bus.MemWbRd_i = 5'd6; bus.MemWbResult_i = 32'h66;
    #1 chk("fwd_rs2_memwb_b", bus.OperandB_o, 32'h66);
    chk("fwd_rs1_none", bus.OperandA_o, 32'd7);
    bus.ExMemRegWrite_i = 1'b1; bus.ExMemRd_i = 5'd6; bus.ExMemResult_i = 32'h77;
    #1 chk("fwd_rs2_exmem_sd", bus.StoreData_o, 32'h77);
    bus.ExMemRd_i = 5'd0; bus.MemWbRd_i = 5'd0;
    drive(1'b1, 32'd11, 32'd12, 32'd0, 5'd0, 5'd0, 5'd3, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(model(1'b1, 32'd11, 32'd12, 32'd0, 5'd3, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("fwd_x0");
    bus.ExMemRegWrite_i = 1'b0; bus.MemWbRegWrite_i = 1'b0;

    // load-use on rs2
    drive(1'b1, 32'd0, 32'd0, 32'h10, 5'd1, 5'd2, 5'd7, 3'd2, 7'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(model(1'b1, 32'd0, 32'd0, 32'h10, 5'd7, 3'd2, 7'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, ecnt));
    step(); check_sb("load");
    chk("haz_nomatch", bus.LoadUseHazard_o, 1'b0);
    drive(1'b1, 32'd3, 32'd4, 32'd0, 5'd1, 5'd7, 5'd8, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("haz_rs2", bus.LoadUseHazard_o, 1'b1);
    bus.Stall_i = 1'b1;
    #1 chk("haz_stall_mask", bus.LoadUseHazard_o, 1'b0);
    bus.Stall_i = 1'b0; bus.Flush_i = 1'b1;
    #1 chk("haz_flush_mask", bus.LoadUseHazard_o, 1'b0);
    bus.Flush_i = 1'b0;
    ecnt++;
    sb.push_back(bubble_exp(ecnt));
    step(); check_sb("lu_bubble");
    chk("haz_after_bubble", bus.LoadUseHazard_o, 1'b0);
    sb.push_back(model(1'b1, 32'd3, 32'd4, 32'd0, 5'd8, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("lu_resume");

    // flush with stall, then pure stall holds
    bus.Flush_i = 1'b1; bus.Stall_i = 1'b1;
    ecnt++;
    sb.push_back(bubble_exp(ecnt));
    step(); check_sb("flush_stall");
    bus.Flush_i = 1'b0; bus.Stall_i = 1'b0;
    drive(1'b1, 32'h1234, 32'h5678, 32'd0, 5'd1, 5'd2, 5'd9, 3'd4, 7'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back(model(1'b1, 32'h1234, 32'h5678, 32'd0, 5'd9, 3'd4, 7'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("pre_stall");
    bus.Stall_i = 1'b1;
    drive(1'b1, 32'hDEAD, 32'hBEEF, 32'h1, 5'd3, 5'd4, 5'd12, 3'd7, 7'h7F, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(1'b1, 32'h1234, 32'h5678, 32'd0, 5'd9, 3'd4, 7'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
      step(); check_sb("stall_hold");
    end
    bus.Stall_i = 1'b0;

    // saturate the counter
    bus.Flush_i = 1'b1;
    for (int i = 0; i < 13; i++) step();
    ecnt = '1;
    chk("cnt_full", 32'(bus.BubbleCnt_o), 32'(ecnt));
    sb.push_back(bubble_exp(ecnt));
    step(); check_sb("cnt_sat");
    bus.Flush_i = 1'b0;

    // async reset while a hazard is pending
    drive(1'b1, 32'd0, 32'd0, 32'h4, 5'd1, 5'd2, 5'd7, 3'd2, 7'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(model(1'b1, 32'd0, 32'd0, 32'h4, 5'd7, 3'd2, 7'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, ecnt));
    step(); check_sb("pre_reset_load");
    drive(1'b1, 32'd41, 32'd42, 32'd0, 5'd7, 5'd2, 5'd4, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk("haz_rs1", bus.LoadUseHazard_o, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", bus.Valid_o, 1'b0);
    chk("arst_memread", bus.MemRead_o, 1'b0);
    chk("arst_regwrite", bus.RegWrite_o, 1'b0);
    chk("arst_rd", 32'(bus.RdAddr_o), 32'd0);
    chk("arst_opb", bus.OperandB_o, 32'd0);
    chk("arst_cnt", 32'(bus.BubbleCnt_o), 32'd0);
    chk("arst_haz", bus.LoadUseHazard_o, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    ecnt = '0;
    sb.push_back(model(1'b1, 32'd41, 32'd42, 32'd0, 5'd4, 3'd0, 7'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, ecnt));
    step(); check_sb("post_reset");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
